// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped 8N1 UART with TX/RX FIFOs in the 0xC000 external window.
// Build option UART_LOOPBACK_EN feeds tx back into the RX synchroniser instead of the rx pin.
module mmio_uart #(
   parameter int          TX_DEPTH    = 8,
   parameter int          RX_DEPTH    = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   input  logic        we,
   input  logic        re,
   output logic [15:0] rdata,
   input  logic        rx,
   output logic        tx
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} st_t;

   logic hit, wr_data, wr_stat, wr_div, rd_data;
   logic [15:0] div_q, div_d;
   logic ovr_q, ovr_d, ferr_q, ferr_d, tovf_q, tovf_d;
   logic [7:0] tx_mem_q [TX_DEPTH];
   logic [TAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [TAW:0] tx_lvl_q, tx_lvl_d;
   logic tx_full, tx_empty, tx_push, tx_pop;
   logic [7:0] rx_mem_q [RX_DEPTH];
   logic [RAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [RAW:0] rx_lvl_q, rx_lvl_d;
   logic rx_full, rx_empty, rx_push, rx_acc, rx_pop, ferr_set;
   st_t tx_st_q, tx_st_d, rx_st_q, rx_st_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_dl_q, tx_dl_d;
   logic [2:0] tx_bit_q, tx_bit_d;
   logic [7:0] tx_sh_q, tx_sh_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_dl_q, rx_dl_d, rx_half;
   logic [2:0] rx_bit_q, rx_bit_d;
   logic [7:0] rx_sh_q, rx_sh_d;
   logic rx_in, s1_q, s2_q, prev_q;
   logic unused_bits;

   assign hit     = addr[15:14] == 2'b11;
   assign wr_data = we & hit & (addr[1:0] == 2'd0);
   assign wr_stat = we & hit & (addr[1:0] == 2'd1);
   assign wr_div  = we & hit & (addr[1:0] == 2'd2);
   assign rd_data = re & hit & (addr[1:0] == 2'd0);

`ifdef UART_LOOPBACK_EN
   assign rx_in       = tx;
   assign unused_bits = ^{addr[13:2], rx};
`else
   assign rx_in       = rx;
   assign unused_bits = ^addr[13:2];
`endif

   assign tx_full  = tx_lvl_q == (TAW+1)'(TX_DEPTH);
   assign tx_empty = tx_lvl_q == '0;
   assign rx_full  = rx_lvl_q == (RAW+1)'(RX_DEPTH);
   assign rx_empty = rx_lvl_q == '0;
   assign tx_push  = wr_data & (~tx_full | tx_pop);
   assign rx_pop   = rd_data & ~rx_empty;
   assign rx_acc   = rx_push & (~rx_full | rx_pop);
   assign tx       = (tx_st_q == S_START) ? 1'b0 : (tx_st_q == S_DATA) ? tx_sh_q[0] : 1'b1;
   assign rx_half  = 16'((17'(rx_dl_q) + 17'd1) >> 1);

   always_comb begin
      rdata = 16'h0000;
      if (re & hit)
         rdata = (addr[1:0] == 2'd0) ? (rx_empty ? 16'h0000 : {8'h00, rx_mem_q[rx_rp_q]}) :
                 (addr[1:0] == 2'd1) ? {8'h00, tovf_q, tx_st_q != S_IDLE, ferr_q, ovr_q,
                                        rx_full, ~rx_empty, tx_empty, tx_full} :
                 (addr[1:0] == 2'd2) ? div_q : 16'h0000;
   end

   always_comb begin
      div_d    = wr_div ? wdata : div_q;
      tovf_d   = (wr_data & tx_full & ~tx_pop) | (tovf_q & ~(wr_stat & wdata[7]));
      ovr_d    = (rx_push & rx_full & ~rx_pop) | (ovr_q & ~(wr_stat & wdata[4]));
      ferr_d   = ferr_set | (ferr_q & ~(wr_stat & wdata[5]));
      tx_wp_d  = tx_wp_q + TAW'(tx_push);
      tx_rp_d  = tx_rp_q + TAW'(tx_pop);
      tx_lvl_d = tx_lvl_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
      rx_wp_d  = rx_wp_q + RAW'(rx_acc);
      rx_rp_d  = rx_rp_q + RAW'(rx_pop);
      rx_lvl_d = rx_lvl_q + (RAW+1)'(rx_acc) - (RAW+1)'(rx_pop);
   end

   // Each frame latches the divisor when it starts so mid-frame writes don't disturb it.
   always_comb begin
      tx_st_d  = tx_st_q;
      tx_cnt_d = tx_cnt_q;
      tx_dl_d  = tx_dl_q;
      tx_bit_d = tx_bit_q;
      tx_sh_d  = tx_sh_q;
      tx_pop   = 1'b0;
      case (tx_st_q)
         S_IDLE: if (!tx_empty) begin
            tx_pop   = 1'b1;
            tx_sh_d  = tx_mem_q[tx_rp_q];
            tx_dl_d  = div_q;
            tx_cnt_d = '0;
            tx_st_d  = S_START;
         end
         S_START: begin
            tx_cnt_d = (tx_cnt_q == tx_dl_q) ? '0 : tx_cnt_q + 16'd1;
            tx_bit_d = '0;
            tx_st_d  = (tx_cnt_q == tx_dl_q) ? S_DATA : S_START;
         end
         S_DATA: begin
            tx_cnt_d = (tx_cnt_q == tx_dl_q) ? '0 : tx_cnt_q + 16'd1;
            if (tx_cnt_q == tx_dl_q) begin
               tx_sh_d  = tx_sh_q >> 1;
               tx_bit_d = tx_bit_q + 3'd1;
               tx_st_d  = (tx_bit_q == 3'd7) ? S_STOP : S_DATA;
            end
         end
         default: begin
            tx_cnt_d = tx_cnt_q + 16'd1;
            if (tx_cnt_q == tx_dl_q) begin
               tx_cnt_d = '0;
               tx_st_d  = tx_empty ? S_IDLE : S_START;
               tx_pop   = ~tx_empty;
               tx_sh_d  = tx_empty ? tx_sh_q : tx_mem_q[tx_rp_q];
               tx_dl_d  = tx_empty ? tx_dl_q : div_q;
            end
         end
      endcase
   end

   always_comb begin
      rx_st_d  = rx_st_q;
      rx_cnt_d = rx_cnt_q + 16'd1;
      rx_dl_d  = rx_dl_q;
      rx_bit_d = rx_bit_q;
      rx_sh_d  = rx_sh_q;
      rx_push  = 1'b0;
      ferr_set = 1'b0;
      case (rx_st_q)
         S_IDLE: begin
            rx_cnt_d = '0;
            if (prev_q & ~s2_q) begin
               rx_dl_d = div_q;
               rx_st_d = S_START;
            end
         end
         S_START: if (rx_cnt_q == rx_half) begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            rx_st_d  = s2_q ? S_IDLE : S_DATA;
         end
         S_DATA: if (rx_cnt_q == rx_dl_q) begin
            rx_cnt_d = '0;
            rx_sh_d  = {s2_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            rx_st_d  = (rx_bit_q == 3'd7) ? S_STOP : S_DATA;
         end
         default: if (rx_cnt_q == rx_dl_q) begin
            rx_push  = s2_q;
            ferr_set = ~s2_q;
            rx_st_d  = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wp_q] <= wdata[7:0];
      if (rx_acc) rx_mem_q[rx_wp_q] <= rx_sh_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q    <= DEFAULT_DIV;
         ovr_q    <= 1'b0;
         ferr_q   <= 1'b0;
         tovf_q   <= 1'b0;
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_lvl_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_lvl_q <= '0;
         tx_st_q  <= S_IDLE;
         tx_cnt_q <= '0;
         tx_dl_q  <= '0;
         tx_bit_q <= '0;
         tx_sh_q  <= '0;
         rx_st_q  <= S_IDLE;
         rx_cnt_q <= '0;
         rx_dl_q  <= '0;
         rx_bit_q <= '0;
         rx_sh_q  <= '0;
         s1_q     <= 1'b1;
         s2_q     <= 1'b1;
         prev_q   <= 1'b1;
      end else begin
         div_q    <= div_d;
         ovr_q    <= ovr_d;
         ferr_q   <= ferr_d;
         tovf_q   <= tovf_d;
         tx_wp_q  <= tx_wp_d;
         tx_rp_q  <= tx_rp_d;
         tx_lvl_q <= tx_lvl_d;
         rx_wp_q  <= rx_wp_d;
         rx_rp_q  <= rx_rp_d;
         rx_lvl_q <= rx_lvl_d;
         tx_st_q  <= tx_st_d;
         tx_cnt_q <= tx_cnt_d;
         tx_dl_q  <= tx_dl_d;
         tx_bit_q <= tx_bit_d;
         tx_sh_q  <= tx_sh_d;
         rx_st_q  <= rx_st_d;
         rx_cnt_q <= rx_cnt_d;
         rx_dl_q  <= rx_dl_d;
         rx_bit_q <= rx_bit_d;
         rx_sh_q  <= rx_sh_d;
         s1_q     <= rx_in;
         s2_q     <= s1_q;
         prev_q   <= s2_q;
      end
   end
endmodule

// File: tb/tb_mmio_uart.sv
// tb_mmio_uart: directed self-checking bench for mmio_uart at div=3.
module tb_mmio_uart;
   logic        clk = 1'b0, rst = 1'b1;
   logic [15:0] addr = '0, wdata = '0, rdata;
   logic        we = 1'b0, re = 1'b0, rx = 1'b1, tx;
   int          n_cmp = 0, n_err = 0;
   logic [15:0] v;
   logic [41:0] s, e;

   mmio_uart dut (.clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
                  .rdata(rdata), .rx(rx), .tx(tx));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      addr = a; wdata = d; we = 1'b1;
      @(posedge clk); #1;
      we = 1'b0;
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] d);
      @(negedge clk);
      addr = a; re = 1'b1;
      #1 d = rdata;
      @(posedge clk); #1;
      re = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic stop);
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         rx = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
         repeat (4) @(negedge clk);
      end
      rx = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("tx_in_reset", tx, 1'b1);
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      do_reset();
      rd(16'hC001, v); check("reset_status", v, 16'h0002);
      rd(16'hC002, v); check("reset_div", v, 16'd433);
      check("reset_tx", tx, 1'b1);
      wr(16'hC002, 16'd3);
      rd(16'hC002, v); check("div_rw", v, 16'd3);
`ifdef UART_LOOPBACK_EN
      wr(16'hC000, 16'h0055);
      repeat (60) @(posedge clk);
      rd(16'hC000, v); check("loopback_byte", v, 16'h0055);
      rd(16'hC001, v); check("loopback_status", v, 16'h0002);
`else
      rd(16'hC003, v); check("reg3_read", v, 16'h0000);
      rd(16'h4001, v); check("nohit_read", v, 16'h0000);
      @(negedge clk) addr = 16'hC001; re = 1'b0;
      #1 check("re_low_rdata", rdata, 16'h0000);

      // TX frame 0xA5: idle sample, 40 frame clocks, idle sample
      e[0] = 1'b1; e[41] = 1'b1;
      for (int k = 0; k < 10; k++)
         for (int j = 0; j < 4; j++)
            e[1+4*k+j] = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : ((8'hA5 >> (k-1)) & 8'h01) != 0;
      wr(16'hC000, 16'h00A5);
      s[0] = tx;
      addr = 16'hC001; re = 1'b1;
      for (int i = 1; i < 42; i++) begin
         @(posedge clk); #1 s[i] = tx;
         if (i == 20) check("tx_busy_mid", rdata[6], 1'b1);
      end
      re = 1'b0;
      check("tx_frame_a5", s, e);
      rd(16'hC001, v); check("tx_done_status", v, 16'h0002);

      for (int i = 0; i < 9; i++) wr(16'hC000, 16'(8'h30 + i));
      rd(16'hC001, v); check("tx_nine_full", v, 16'h0041);
      wr(16'hC000, 16'h00EE);
      rd(16'hC001, v); check("tx_overflow", v, 16'h00C1);
      wr(16'hC001, 16'h0080);
      rd(16'hC001, v); check("tx_ovf_clear", v, 16'h0041);
      repeat (420) @(posedge clk);
      rd(16'hC001, v); check("tx_drained", v, 16'h0002);

      send(8'h3C, 1'b1);
      rd(16'hC001, v); check("rx_valid", v, 16'h0006);
      rd(16'hC000, v); check("rx_byte", v, 16'h003C);
      rd(16'hC001, v); check("rx_popped", v, 16'h0002);
      rd(16'hC000, v); check("rx_empty_read", v, 16'h0000);

      send(8'h5A, 1'b0);
      rd(16'hC001, v); check("frame_err", v, 16'h0022);
      wr(16'hC001, 16'h0020);
      rd(16'hC001, v); check("ferr_clear", v, 16'h0002);

      @(negedge clk) rx = 1'b0;
      @(negedge clk) rx = 1'b1;
      repeat (50) @(posedge clk);
      rd(16'hC001, v); check("glitch_ignored", v, 16'h0002);

      for (int i = 0; i < 9; i++) send(8'h10 + 8'(i), 1'b1);
      rd(16'hC001, v); check("rx_overrun", v, 16'h001E);
      for (int i = 0; i < 8; i++) begin
         rd(16'hC000, v); check("rx_fifo_order", v, 16'(8'h10 + i));
      end
      rd(16'hC001, v); check("rx_ovr_sticky", v, 16'h0012);
      wr(16'hC001, 16'h0010);
      rd(16'hC001, v); check("ovr_clear", v, 16'h0002);
`endif
      wr(16'hC000, 16'h0000);
      repeat (10) @(posedge clk);
      #2 check("tx_low_midframe", tx, 1'b0);
      #1 rst = 1'b1;
      #1 check("async_reset_tx", tx, 1'b1);
      @(negedge clk) rst = 1'b0;
      rd(16'hC001, v); check("post_reset_status", v, 16'h0002);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
